// File: rtl/axi_lite_arbiter.sv
// Two-master AXI4-Lite arbiter with independent read/write FSMs; ARB_M0_PRIORITY_EN selects fixed priority.
// Latency: 1 cycle from master valid to m_*valid; channel forwarding is combinational.
// Backpressure: ready/valid pass straight through for the held grant; one outstanding transaction per direction.
module axi_lite_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                CLK,
    input  logic                RSTb,
    input  logic                s0_awvalid,
    input  logic [ADDR_W-1:0]   s0_awaddr,
    input  logic [2:0]          s0_awprot,
    output logic                s0_awready,
    input  logic                s0_wvalid,
    input  logic [DATA_W-1:0]   s0_wdata,
    input  logic [DATA_W/8-1:0] s0_wstrb,
    output logic                s0_wready,
    output logic                s0_bvalid,
    input  logic                s0_bready,
    input  logic                s0_arvalid,
    input  logic [ADDR_W-1:0]   s0_araddr,
    input  logic [2:0]          s0_arprot,
    output logic                s0_arready,
    output logic                s0_rvalid,
    output logic [DATA_W-1:0]   s0_rdata,
    input  logic                s0_rready,
    input  logic                s1_awvalid,
    input  logic [ADDR_W-1:0]   s1_awaddr,
    input  logic [2:0]          s1_awprot,
    output logic                s1_awready,
    input  logic                s1_wvalid,
    input  logic [DATA_W-1:0]   s1_wdata,
    input  logic [DATA_W/8-1:0] s1_wstrb,
    output logic                s1_wready,
    output logic                s1_bvalid,
    input  logic                s1_bready,
    input  logic                s1_arvalid,
    input  logic [ADDR_W-1:0]   s1_araddr,
    input  logic [2:0]          s1_arprot,
    output logic                s1_arready,
    output logic                s1_rvalid,
    output logic [DATA_W-1:0]   s1_rdata,
    input  logic                s1_rready,
    output logic                m_awvalid,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [2:0]          m_awprot,
    input  logic                m_awready,
    output logic                m_wvalid,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic                m_wready,
    input  logic                m_bvalid,
    output logic                m_bready,
    output logic                m_arvalid,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [2:0]          m_arprot,
    input  logic                m_arready,
    input  logic                m_rvalid,
    input  logic [DATA_W-1:0]   m_rdata,
    output logic                m_rready,
    output logic [1:0]          rd_grant,
    output logic [1:0]          wr_grant
);

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;

    rd_state_t  rd_state, rd_state_nxt;
    wr_state_t  wr_state, wr_state_nxt;
    logic [1:0] rd_grant_nxt, wr_grant_nxt;
    logic [1:0] rd_pick, wr_pick;
    logic       rd_done, wr_done;

    assign rd_done = (rd_state == R_DATA) && m_rvalid && m_rready;
    assign wr_done = (wr_state == W_RESP) && m_bvalid && m_bready;

`ifdef ARB_M0_PRIORITY_EN
    assign rd_pick = s0_arvalid ? 2'b01 : {s1_arvalid, 1'b0};
    assign wr_pick = s0_awvalid ? 2'b01 : {s1_awvalid, 1'b0};
`else
    // last = 1 means master 1 was served most recently, so master 0 wins the next tie.
    logic rd_last, wr_last;

    assign rd_pick = (s0_arvalid && (!s1_arvalid || rd_last)) ? 2'b01 : {s1_arvalid, 1'b0};
    assign wr_pick = (s0_awvalid && (!s1_awvalid || wr_last)) ? 2'b01 : {s1_awvalid, 1'b0};

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            rd_last <= 1'b1;
            wr_last <= 1'b1;
        end else begin
            if (rd_done) rd_last <= rd_grant[1];
            if (wr_done) wr_last <= wr_grant[1];
        end
    end
`endif

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            rd_state <= R_IDLE;
            wr_state <= W_IDLE;
            rd_grant <= 2'b00;
            wr_grant <= 2'b00;
        end else begin
            rd_state <= rd_state_nxt;
            wr_state <= wr_state_nxt;
            rd_grant <= rd_grant_nxt;
            wr_grant <= wr_grant_nxt;
        end
    end

    always_comb begin
        rd_state_nxt = rd_state;
        rd_grant_nxt = rd_grant;
        case (rd_state)
            R_IDLE: if (|rd_pick) begin
                rd_state_nxt = R_ADDR;
                rd_grant_nxt = rd_pick;
            end
            R_ADDR: if (m_arvalid && m_arready) rd_state_nxt = R_DATA;
            R_DATA: if (rd_done) begin
                rd_state_nxt = R_IDLE;
                rd_grant_nxt = 2'b00;
            end
            default: begin
                rd_state_nxt = R_IDLE;
                rd_grant_nxt = 2'b00;
            end
        endcase
    end

    always_comb begin
        wr_state_nxt = wr_state;
        wr_grant_nxt = wr_grant;
        case (wr_state)
            W_IDLE: if (|wr_pick) begin
                wr_state_nxt = W_ADDR;
                wr_grant_nxt = wr_pick;
            end
            W_ADDR: if (m_awvalid && m_awready) wr_state_nxt = W_DATA;
            W_DATA: if (m_wvalid && m_wready) wr_state_nxt = W_RESP;
            W_RESP: if (wr_done) begin
                wr_state_nxt = W_IDLE;
                wr_grant_nxt = 2'b00;
            end
            default: begin
                wr_state_nxt = W_IDLE;
                wr_grant_nxt = 2'b00;
            end
        endcase
    end

    // Read channel steering; every handshake signal is qualified by state and grant.
    assign m_arvalid  = (rd_state == R_ADDR) && (rd_grant[1] ? s1_arvalid : s0_arvalid);
    assign m_araddr   = rd_grant[1] ? s1_araddr : s0_araddr;
    assign m_arprot   = rd_grant[1] ? s1_arprot : s0_arprot;
    assign s0_arready = (rd_state == R_ADDR) && rd_grant[0] && m_arready;
    assign s1_arready = (rd_state == R_ADDR) && rd_grant[1] && m_arready;
    assign m_rready   = (rd_state == R_DATA) && (rd_grant[1] ? s1_rready : s0_rready);
    assign s0_rvalid  = (rd_state == R_DATA) && rd_grant[0] && m_rvalid;
    assign s1_rvalid  = (rd_state == R_DATA) && rd_grant[1] && m_rvalid;
    assign s0_rdata   = ((rd_state == R_DATA) && rd_grant[0]) ? m_rdata : '0;
    assign s1_rdata   = ((rd_state == R_DATA) && rd_grant[1]) ? m_rdata : '0;

    assign m_awvalid  = (wr_state == W_ADDR) && (wr_grant[1] ? s1_awvalid : s0_awvalid);
    assign m_awaddr   = wr_grant[1] ? s1_awaddr : s0_awaddr;
    assign m_awprot   = wr_grant[1] ? s1_awprot : s0_awprot;
    assign s0_awready = (wr_state == W_ADDR) && wr_grant[0] && m_awready;
    assign s1_awready = (wr_state == W_ADDR) && wr_grant[1] && m_awready;
    assign m_wvalid   = (wr_state == W_DATA) && (wr_grant[1] ? s1_wvalid : s0_wvalid);
    assign m_wdata    = wr_grant[1] ? s1_wdata : s0_wdata;
    assign m_wstrb    = wr_grant[1] ? s1_wstrb : s0_wstrb;
    assign s0_wready  = (wr_state == W_DATA) && wr_grant[0] && m_wready;
    assign s1_wready  = (wr_state == W_DATA) && wr_grant[1] && m_wready;
    assign m_bready   = (wr_state == W_RESP) && (wr_grant[1] ? s1_bready : s0_bready);
    assign s0_bvalid  = (wr_state == W_RESP) && wr_grant[0] && m_bvalid;
    assign s1_bvalid  = (wr_state == W_RESP) && wr_grant[1] && m_bvalid;

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter with a small memory-controller model.
// Table of read vectors plus hand sequences for concurrency, backpressure and reset.
module tb_axi_lite_arbiter;
    logic CLK = 1'b0;
    logic RSTb = 1'b0;
    always #5 CLK = ~CLK;

    logic        s0_awvalid, s0_awready, s0_wvalid, s0_wready, s0_bvalid, s0_bready;
    logic        s0_arvalid, s0_arready, s0_rvalid, s0_rready;
    logic [31:0] s0_awaddr, s0_wdata, s0_araddr, s0_rdata;
    logic [2:0]  s0_awprot, s0_arprot;
    logic [3:0]  s0_wstrb;
    logic        s1_awvalid, s1_awready, s1_wvalid, s1_wready, s1_bvalid, s1_bready;
    logic        s1_arvalid, s1_arready, s1_rvalid, s1_rready;
    logic [31:0] s1_awaddr, s1_wdata, s1_araddr, s1_rdata;
    logic [2:0]  s1_awprot, s1_arprot;
    logic [3:0]  s1_wstrb;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [2:0]  m_awprot, m_arprot;
    logic [3:0]  m_wstrb;
    logic [1:0]  rd_grant, wr_grant;

    axi_lite_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .CLK(CLK), .RSTb(RSTb),
        .s0_awvalid(s0_awvalid), .s0_awaddr(s0_awaddr), .s0_awprot(s0_awprot), .s0_awready(s0_awready),
        .s0_wvalid(s0_wvalid), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wready(s0_wready),
        .s0_bvalid(s0_bvalid), .s0_bready(s0_bready),
        .s0_arvalid(s0_arvalid), .s0_araddr(s0_araddr), .s0_arprot(s0_arprot), .s0_arready(s0_arready),
        .s0_rvalid(s0_rvalid), .s0_rdata(s0_rdata), .s0_rready(s0_rready),
        .s1_awvalid(s1_awvalid), .s1_awaddr(s1_awaddr), .s1_awprot(s1_awprot), .s1_awready(s1_awready),
        .s1_wvalid(s1_wvalid), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wready(s1_wready),
        .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
        .s1_arvalid(s1_arvalid), .s1_araddr(s1_araddr), .s1_arprot(s1_arprot), .s1_arready(s1_arready),
        .s1_rvalid(s1_rvalid), .s1_rdata(s1_rdata), .s1_rready(s1_rready),
        .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awready(m_awready),
        .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rready(m_rready),
        .rd_grant(rd_grant), .wr_grant(wr_grant)
    );

    // Memory-controller model: always ready for addresses/data, response one cycle later.
    logic [31:0] mem [32];
    logic        rv_q, bv_q;
    logic [31:0] rd_q, aw_q;

    function automatic logic [4:0] midx(input logic [31:0] a);
        return {a[28], a[5:2]};
    endfunction

    assign m_arready = 1'b1;
    assign m_awready = 1'b1;
    assign m_wready  = 1'b1;
    assign m_rvalid  = rv_q;
    assign m_rdata   = rd_q;
    assign m_bvalid  = bv_q;

    always @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            rv_q <= 1'b0;
            bv_q <= 1'b0;
            rd_q <= '0;
            aw_q <= '0;
            for (int i = 0; i < 32; i++) mem[i] <= '0;
            mem[midx(32'h0000_0000)] <= 32'hDEAD_BEEF;
            mem[midx(32'h1000_0000)] <= 32'hCAFE_F00D;
            mem[midx(32'h1000_0004)] <= 32'h1234_5678;
        end else begin
            if (m_arvalid && m_arready) begin
                rv_q <= 1'b1;
                rd_q <= mem[midx(m_araddr)];
            end else if (rv_q && m_rready) begin
                rv_q <= 1'b0;
            end
            if (m_awvalid && m_awready) aw_q <= m_awaddr;
            if (m_wvalid && m_wready) begin
                for (int b = 0; b < 4; b++)
                    if (m_wstrb[b]) mem[midx(aw_q)][8*b +: 8] <= m_wdata[8*b +: 8];
                bv_q <= 1'b1;
            end else if (bv_q && m_bready) begin
                bv_q <= 1'b0;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        s0_awvalid = 0; s0_awaddr = '0; s0_awprot = '0; s0_wvalid = 0; s0_wdata = '0; s0_wstrb = '0;
        s0_bready = 1; s0_arvalid = 0; s0_araddr = '0; s0_arprot = '0; s0_rready = 1;
        s1_awvalid = 0; s1_awaddr = '0; s1_awprot = '0; s1_wvalid = 0; s1_wdata = '0; s1_wstrb = '0;
        s1_bready = 1; s1_arvalid = 0; s1_araddr = '0; s1_arprot = '0; s1_rready = 1;
    endtask

    // Each master issues n reads back to back; grant order recorded as one bit per grant (1 = master 1).
    task automatic run_reads(input int n0, input int n1, input logic [31:0] a0, input logic [31:0] a1,
                             output logic [7:0] ord, output int nord, output logic [31:0] d0,
                             output logic [31:0] d1, output int lat, output bit viol);
        int left0, left1, cyc;
        logic [1:0] prev;
        bit hs0, hs1, rs0, rs1;
        left0 = n0; left1 = n1; cyc = 0; prev = 2'b00;
        ord = '0; nord = 0; d0 = '0; d1 = '0; lat = -1; viol = 0;
        s0_araddr = a0; s1_araddr = a1; s0_rready = 1; s1_rready = 1;
        s0_arvalid = (n0 > 0); s1_arvalid = (n1 > 0);
        while ((left0 > 0 || left1 > 0) && cyc < 200) begin
            @(negedge CLK);
            if (lat < 0 && m_arvalid) lat = cyc;
            if (rd_grant != 2'b00 && rd_grant != prev) begin
                if (nord < 8) ord[nord] = rd_grant[1];
                nord++;
            end
            prev = rd_grant;
            if ((s0_rvalid && !rd_grant[0]) || (s1_rvalid && !rd_grant[1])) viol = 1;
            hs0 = s0_arvalid && s0_arready;
            hs1 = s1_arvalid && s1_arready;
            rs0 = s0_rvalid && s0_rready;
            rs1 = s1_rvalid && s1_rready;
            if (rs0) d0 = s0_rdata;
            if (rs1) d1 = s1_rdata;
            @(posedge CLK); #1;
            cyc++;
            if (hs0) s0_arvalid = 0;
            if (hs1) s1_arvalid = 0;
            if (rs0) begin left0--; s0_arvalid = (left0 > 0); end
            if (rs1) begin left1--; s1_arvalid = (left1 > 0); end
        end
        s0_arvalid = 0; s1_arvalid = 0;
        check("reads_complete", left0 + left1, 0);
    endtask

    typedef struct {
        int          n0, n1;
        logic [31:0] a0, a1;
        logic [7:0]  ord;
        int          nord;
        logic [31:0] d0, d1;
    } rvec_t;

    rvec_t       tbl [4];
    logic [7:0]  g_ord;
    int          g_nord, g_lat;
    logic [31:0] g_d0, g_d1;
    bit          g_viol;

    initial begin
        bit done_r, done_b, aw_done, w_done, ordviol, found, bp_ok, bseen;
        logic [31:0] rdat;
        int cyc;

`ifdef ARB_M0_PRIORITY_EN
        tbl[0] = '{4, 4, 32'h0000_0000, 32'h1000_0000, 8'hF0, 8, 32'hDEAD_BEEF, 32'hCAFE_F00D};
`else
        tbl[0] = '{4, 4, 32'h0000_0000, 32'h1000_0000, 8'hAA, 8, 32'hDEAD_BEEF, 32'hCAFE_F00D};
`endif
        tbl[1] = '{1, 0, 32'h1000_0004, 32'h0000_0000, 8'h00, 1, 32'h1234_5678, 32'h0};
        tbl[2] = '{0, 1, 32'h0000_0000, 32'h1000_0004, 8'h01, 1, 32'h0, 32'h1234_5678};
        tbl[3] = '{1, 1, 32'h1000_0000, 32'h0000_0000, 8'h02, 2, 32'hCAFE_F00D, 32'hDEAD_BEEF};

        clear_inputs();
        repeat (2) @(negedge CLK);
        check("reset_grants", {30'b0, rd_grant | wr_grant}, 32'h0);
        check("reset_valids", {22'b0, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready,
                               s0_rvalid, s1_rvalid, s0_bvalid, s1_bvalid, s0_arready}, 32'h0);
        check("reset_rdata", s0_rdata | s1_rdata, 32'h0);
        RSTb = 1'b1;
        @(posedge CLK); #1;

        for (int v = 0; v < 4; v++) begin
            run_reads(tbl[v].n0, tbl[v].n1, tbl[v].a0, tbl[v].a1, g_ord, g_nord, g_d0, g_d1, g_lat, g_viol);
            check($sformatf("v%0d_order", v), {24'b0, g_ord}, {24'b0, tbl[v].ord});
            check($sformatf("v%0d_ngrants", v), g_nord, tbl[v].nord);
            check($sformatf("v%0d_d0", v), g_d0, tbl[v].d0);
            check($sformatf("v%0d_d1", v), g_d1, tbl[v].d1);
            check($sformatf("v%0d_latency", v), g_lat, 1);
            check($sformatf("v%0d_exclusive", v), {31'b0, g_viol}, 0);
        end

        // Master 0 reads ROM while master 1 writes the scratchpad.
        s0_araddr = 32'h0; s0_arvalid = 1;
        s1_awaddr = 32'h1000_0010; s1_awvalid = 1;
        s1_wdata = 32'hA5A5_A5A5; s1_wstrb = 4'hF; s1_wvalid = 1;
        done_r = 0; done_b = 0; aw_done = 0; w_done = 0; ordviol = 0; rdat = '0; cyc = 0;
        while (!(done_r && done_b) && cyc < 50) begin
            bit hsa, hsaw, hsw, rs, bs;
            @(negedge CLK);
            if (cyc == 1) begin
                check("conc_rd_grant", {30'b0, rd_grant}, 32'h1);
                check("conc_wr_grant", {30'b0, wr_grant}, 32'h2);
            end
            if ((s1_wready && !aw_done) || (s1_bvalid && !w_done)) ordviol = 1;
            hsa = s0_arvalid && s0_arready;
            hsaw = s1_awvalid && s1_awready;
            hsw = s1_wvalid && s1_wready;
            rs = s0_rvalid && s0_rready;
            bs = s1_bvalid && s1_bready;
            if (rs) rdat = s0_rdata;
            @(posedge CLK); #1;
            cyc++;
            if (hsa) s0_arvalid = 0;
            if (hsaw) begin s1_awvalid = 0; aw_done = 1; end
            if (hsw) begin s1_wvalid = 0; w_done = 1; end
            if (rs) done_r = 1;
            if (bs) done_b = 1;
        end
        check("conc_done", {30'b0, done_r, done_b}, 32'h3);
        check("conc_rdata", rdat, 32'hDEAD_BEEF);
        check("conc_wr_sequence", {31'b0, ordviol}, 0);
        run_reads(1, 0, 32'h1000_0010, 32'h0, g_ord, g_nord, g_d0, g_d1, g_lat, g_viol);
        check("conc_readback", g_d0, 32'hA5A5_A5A5);

        // Master 1 stalls the read data channel for 5 cycles.
        s1_araddr = 32'h1000_0004; s1_arvalid = 1; s1_rready = 0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge CLK);
            found = s1_arvalid && s1_arready;
            @(posedge CLK); #1;
        end
        s1_arvalid = 0;
        check("bp_ar_accepted", {31'b0, found}, 1);
        bp_ok = 1;
        repeat (5) begin
            @(negedge CLK);
            if (!(m_rvalid && !m_rready && rd_grant == 2'b10 && s1_rvalid)) bp_ok = 0;
            @(posedge CLK); #1;
        end
        check("bp_held", {31'b0, bp_ok}, 1);
        s1_rready = 1;
        @(negedge CLK);
        check("bp_m_rready", {31'b0, m_rready}, 1);
        check("bp_rdata", s1_rdata, 32'h1234_5678);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("bp_released", {30'b0, rd_grant}, 32'h0);
        @(posedge CLK); #1;

        // Reset arrives while a write from master 0 sits in the data phase.
        s0_awaddr = 32'h1000_0010; s0_awvalid = 1; s0_wvalid = 0;
        s0_wdata = 32'h1122_3344; s0_wstrb = 4'b0011; s0_bready = 1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge CLK);
            found = s0_awvalid && s0_awready;
            @(posedge CLK); #1;
        end
        s0_awvalid = 0;
        check("rst_aw_accepted", {31'b0, found}, 1);
        @(negedge CLK);
        s0_wvalid = 1;
        #1;
        check("rst_pre_wvalid", {31'b0, m_wvalid}, 1);
        RSTb = 1'b0;
        #1;
        check("rst_wr_grant", {30'b0, wr_grant}, 32'h0);
        check("rst_outputs", {24'b0, s0_awready, s0_wready, s0_bvalid, m_awvalid, m_wvalid, m_bready,
                              s1_wready, s1_bvalid}, 32'h0);
        @(negedge CLK);
        clear_inputs();
        RSTb = 1'b1;
        @(posedge CLK); #1;

        s0_awaddr = 32'h1000_0010; s0_awvalid = 1;
        s0_wdata = 32'h1122_3344; s0_wstrb = 4'b0011; s0_wvalid = 1; s0_bready = 1;
        bseen = 0;
        for (int i = 0; i < 50 && !bseen; i++) begin
            bit hsaw, hsw;
            @(negedge CLK);
            hsaw = s0_awvalid && s0_awready;
            hsw = s0_wvalid && s0_wready;
            bseen = s0_bvalid && s0_bready;
            @(posedge CLK); #1;
            if (hsaw) s0_awvalid = 0;
            if (hsw) s0_wvalid = 0;
        end
        s0_awvalid = 0; s0_wvalid = 0;
        check("post_rst_bvalid", {31'b0, bseen}, 1);
        run_reads(1, 0, 32'h1000_0010, 32'h0, g_ord, g_nord, g_d0, g_d1, g_lat, g_viol);
        check("post_rst_strobed_data", g_d0, 32'h0000_3344);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/axi_lite_arbiter.md
# axi_lite_arbiter

Two-master AXI4-Lite arbiter sharing the single memory-controller slave port (boot ROM, scratchpad, UART) between master 0 (CPU) and master 1 (second requester, e.g. DMA or debug). Independent read and write arbiters; one outstanding transaction per direction. Grants are registered; channel signals are muxed by the held grant.

## Interface
- `ADDR_W`, 32: address width, all ports.
- `DATA_W`, 32: data width, all ports.
- `CLK`  in  1  system clock.
- `RSTb`  in  1  asynchronous active-low reset.
- `s0_awvalid/awaddr/awprot`, `s1_…`  in  1/ADDR_W/3  master write address.
- `s0_awready`, `s1_awready`  out  1  write address accept.
- `s0_wvalid/wdata/wstrb`, `s1_…`  in  1/DATA_W/4  master write data.
- `s0_wready`, `s1_wready`  out  1  write data accept.
- `s0_bvalid`, `s1_bvalid`  out  1; `s0_bready`, `s1_bready`  in  1  write response.
- `s0_arvalid/araddr/arprot`, `s1_…`  in  1/ADDR_W/3; `s0_arready`, `s1_arready`  out  1  read address.
- `s0_rvalid/rdata`, `s1_…`  out  1/DATA_W; `s0_rready`, `s1_rready`  in  1  read data.
- `m_aw*`, `m_w*`, `m_b*`, `m_ar*`, `m_r*`: same set with mirrored directions, to the memory controller.
- `rd_grant`  out  2  one-hot read owner; 0 when idle.
- `wr_grant`  out  2  one-hot write owner; 0 when idle.

## Operation
- Read FSM: `R_IDLE -> R_ADDR -> R_DATA -> R_IDLE`.
  - `R_IDLE`: if any `sN_arvalid`, register the winner into `rd_grant` and go to `R_ADDR`.
  - `R_ADDR`: `m_ar*` = granted `s_ar*`; granted `arready` = `m_arready`. On `m_arvalid & m_arready`, go to `R_DATA`.
  - `R_DATA`: granted `rvalid/rdata` = `m_rvalid/m_rdata`; `m_rready` = granted `rready`. On the handshake, go to `R_IDLE` and update the priority pointer.
- Write FSM: `W_IDLE -> W_ADDR -> W_DATA -> W_RESP -> W_IDLE`. Same grant rule; aw, w and b are forwarded strictly in sequence, one channel per state.
- Idle-state outputs:
  - Outside its forwarding state, every `m_*valid` and `m_*ready` is 0.
  - Ungranted masters see all `ready`/`valid` = 0 and `rdata` = 0.
- Round-robin arbitration:
  - Per-direction pointer `last`; on simultaneous requests the master ≠ `last` wins.
  - Reset value of `last` = 1, so master 0 wins first.
  - A single requester always wins.
  - A request stays pending while it waits.
- Read and write are fully independent: a read by one master and a write by the other may overlap.
- Reset, asynchronous and at any point including mid-transaction:
  - Both FSMs go to IDLE and both pointers go to 1.
  - All valid/ready outputs, `rd_grant` and `wr_grant` = 0; `rdata` outputs = 0.
  - The in-flight transaction is abandoned; the downstream controller shares `RSTb`.

## Timing
- Arbitration latency: 1 cycle from `sN_arvalid`/`awvalid` to `m_arvalid`/`m_awvalid`.
- Forwarding is combinational: ready→ready, valid→valid, data→data. No output `valid` depends on any `ready`.
- Back-to-back throughput: one IDLE cycle between transactions in each direction.
- A request that drops `valid` before `R_ADDR`/`W_ADDR` handshakes is an AXI violation and is not handled.
- Starvation bound: with both masters saturating, each waits at most one transaction of the other.

## Configuration
- `ARB_M0_PRIORITY_EN` defined:
  - Fixed priority; master 0 always wins simultaneous requests.
  - `last` pointers are not implemented.
  - Master 1 may starve.
- Not defined: round-robin as above.

## Test plan
- Single read, master 0: `s0_araddr`=0x10000004 with scratchpad word 0x12345678 → `rd_grant`=01; `m_arvalid` 1 cycle after `s0_arvalid`; `s0_rdata`=0x12345678; `s1_rvalid` stays 0.
- Simultaneous reads from both masters (0x00000000 and 0x10000000), repeated 4×:
  - Round-robin build: grant order 0,1,0,1.
  - `ARB_M0_PRIORITY_EN` build: master 0 served 4× first.
- Concurrent read and write: master 0 reads ROM 0x00000000 while master 1 writes 0xA5A5A5A5 (wstrb=0xF) to 0x10000010.
  - `rd_grant`=01 and `wr_grant`=10 in the same cycle.
  - A subsequent read of 0x10000010 returns 0xA5A5A5A5.
- Backpressure: master 1 holds `s1_rready`=0 for 5 cycles → `m_rvalid` held, `m_rready`=0 throughout; `rd_grant` stays 10 until the handshake.
- Reset mid-write: `RSTb` low during `W_DATA` → same cycle all ready/valid = 0, `wr_grant`=0; after release, a fresh write from master 0 completes with `s0_bvalid`.
